// File: rtl/csv_field_parser.sv
// csv_field_parser: pops ASCII characters from a FIFO and turns comma/newline
// delimited decimal fields into binary values on a valid/ready output.
`default_nettype none

module csv_field_parser #(
  parameter int WIDTH     = 8,
  parameter int VAL_WIDTH = 16,
  parameter int COL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_rready,
  output logic                 fifo_rreq,
  output logic [VAL_WIDTH-1:0] field_value,
  output logic [COL_WIDTH-1:0] field_col,
  output logic                 field_last,
  output logic                 field_err,
  output logic                 field_valid,
  input  logic                 field_ready
);

  localparam logic [WIDTH-1:0] c_COMMA = WIDTH'('h2C);
  localparam logic [WIDTH-1:0] c_LF    = WIDTH'('h0A);
  localparam logic [WIDTH-1:0] c_CR    = WIDTH'('h0D);
  localparam logic [WIDTH-1:0] c_SPACE = WIDTH'('h20);
  localparam logic [WIDTH-1:0] c_ZERO  = WIDTH'('h30);
  localparam logic [WIDTH-1:0] c_NINE  = WIDTH'('h39);

  logic                 r_rd_valid;
  logic                 r_pend_valid;
  logic [WIDTH-1:0]     r_pend;
  logic [VAL_WIDTH-1:0] r_acc;
  logic [COL_WIDTH-1:0] r_col;
  logic                 r_err;
  logic                 r_nonempty;

  logic [WIDTH-1:0]     w_char;
  logic                 w_have;
  logic                 w_is_delim;
  logic                 w_is_lf;
  logic                 w_is_digit;
  logic                 w_is_skip;
  logic                 w_stall;
  logic                 w_consume;
  logic                 w_emit;
  logic [3:0]           w_digit;
  logic [VAL_WIDTH+3:0] w_acc_wide;
  logic                 w_ovf;

  assign w_char     = r_pend_valid ? r_pend : fifo_rdata;
  assign w_have     = r_pend_valid | r_rd_valid;
  assign w_is_lf    = (w_char == c_LF);
  assign w_is_delim = (w_char == c_COMMA) | w_is_lf;
  assign w_is_digit = (w_char >= c_ZERO) & (w_char <= c_NINE);
  assign w_is_skip  = (w_char == c_CR) | (w_char == c_SPACE);
  assign w_stall    = w_have & w_is_delim & field_valid & ~field_ready;
  assign w_consume  = w_have & ~w_stall;
  // A newline on a row with no columns and no content is a blank line.
  assign w_emit     = ~(w_is_lf & (r_col == '0) & ~r_nonempty);

  // ASCII digits carry their value in the low nibble; acc*10 = acc*8 + acc*2.
  assign w_digit    = w_char[3:0];
  assign w_acc_wide = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                    + {{VAL_WIDTH{1'b0}}, w_digit};
  assign w_ovf      = |w_acc_wide[VAL_WIDTH+3:VAL_WIDTH];

  assign fifo_rreq  = fifo_rready & ~r_pend_valid & ~w_stall & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_acc        <= '0;
      r_col        <= '0;
      r_err        <= 1'b0;
      r_nonempty   <= 1'b0;
      field_value  <= '0;
      field_col    <= '0;
      field_last   <= 1'b0;
      field_err    <= 1'b0;
      field_valid  <= 1'b0;
    end else begin
      r_rd_valid <= fifo_rreq;

      if (w_stall & ~r_pend_valid) begin
        r_pend       <= fifo_rdata;
        r_pend_valid <= 1'b1;
      end else if (r_pend_valid & ~w_stall) begin
        r_pend_valid <= 1'b0;
      end

      if (field_valid & field_ready) begin
        field_valid <= 1'b0;
      end

      if (w_consume) begin
        if (w_is_digit) begin
          r_nonempty <= 1'b1;
          if (w_ovf) begin
            r_acc <= '1;
            r_err <= 1'b1;
          end else begin
            r_acc <= w_acc_wide[VAL_WIDTH-1:0];
          end
        end else if (w_is_delim) begin
          if (w_emit) begin
            field_value <= r_acc;
            field_col   <= r_col;
            field_last  <= w_is_lf;
            field_err   <= r_err;
            field_valid <= 1'b1;
          end
          r_col      <= w_is_lf ? '0 : r_col + 1'b1;
          r_acc      <= '0;
          r_err      <= 1'b0;
          r_nonempty <= 1'b0;
        end else if (!w_is_skip) begin
          r_err      <= 1'b1;
          r_nonempty <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
